// File: rtl/dbus_responder.sv
// Data-bus target: word RAM at address 0 plus an MMIO window (cycle counter, compare timer, DONE mailbox).
// Optional build macro DBUS_ERR_EN adds a sticky bus_err flag for unmapped writes and writes to CYCLE.
module dbus_responder #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        timer_irq,
  output logic        done,
  output logic [31:0] done_value,
  output logic        bus_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OFF_CYCLE = 6'h00;
  localparam logic [5:0] OFF_TCMP  = 6'h01;
  localparam logic [5:0] OFF_TCTRL = 6'h02;
  localparam logic [5:0] OFF_TCNT  = 6'h03;
  localparam logic [5:0] OFF_TSTAT = 6'h04;
  localparam logic [5:0] OFF_DONE  = 6'h05;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   cycle_cnt;
  logic [31:0]   tcmp;
  logic [31:0]   tcnt;
  logic          tmr_en;
  logic          tmr_ar;
  logic          pend;

  logic          ram_hit;
  logic          mmio_hit;
  logic [5:0]    off;
  logic [AW-1:0] ram_idx;
  logic          we_tcmp, we_tctrl, we_tcnt, we_tstat, we_done;
  logic          match;
  logic [31:0]   tcnt_nxt;
  logic          en_nxt;
  logic          pend_nxt;

  // Byte-lane bits are ignored; only word accesses exist on this bus.
  logic unused_lane;
  assign unused_lane = ^DataAdr[1:0];

  assign ram_hit  = (DataAdr[31:AW+2] == '0);
  assign mmio_hit = (DataAdr[31:8] == MMIO_BASE[31:8]);
  assign off      = DataAdr[7:2];
  assign ram_idx  = DataAdr[AW+1:2];

  assign we_tcmp  = MemWrite && mmio_hit && (off == OFF_TCMP);
  assign we_tctrl = MemWrite && mmio_hit && (off == OFF_TCTRL);
  assign we_tcnt  = MemWrite && mmio_hit && (off == OFF_TCNT);
  assign we_tstat = MemWrite && mmio_hit && (off == OFF_TSTAT);
  assign we_done  = MemWrite && mmio_hit && (off == OFF_DONE);

  // A bus write to TCNT or TCTRL cancels the timer's own count/disable step for that edge.
  always_comb begin
    match    = tmr_en && (tcnt == tcmp);
    tcnt_nxt = tcnt;
    en_nxt   = tmr_en;
    if (tmr_en) begin
      if (match) begin
        if (tmr_ar) tcnt_nxt = '0;
        else        en_nxt   = 1'b0;
      end else begin
        tcnt_nxt = tcnt + 32'd1;
      end
    end
    if (we_tcnt) begin
      tcnt_nxt = WriteData;
      en_nxt   = tmr_en;
    end
    if (we_tctrl) begin
      tcnt_nxt = we_tcnt ? WriteData : tcnt;
      en_nxt   = WriteData[0];
    end
    pend_nxt = pend;
    if (we_tstat && WriteData[0]) pend_nxt = 1'b0;
    if (match)                    pend_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt  <= '0;
      tcmp       <= '0;
      tcnt       <= '0;
      tmr_en     <= 1'b0;
      tmr_ar     <= 1'b0;
      pend       <= 1'b0;
      timer_irq  <= 1'b0;
      done       <= 1'b0;
      done_value <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (we_tcmp)  tcmp   <= WriteData;
      if (we_tctrl) tmr_ar <= WriteData[1];
      tcnt      <= tcnt_nxt;
      tmr_en    <= en_nxt;
      pend      <= pend_nxt;
      timer_irq <= pend_nxt;
      if (we_done) begin
        done       <= 1'b1;
        done_value <= WriteData;
      end
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) mem[ram_idx] <= WriteData;
  end

`ifdef DBUS_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err <= 1'b0;
    end else if (MemWrite && ((!ram_hit && !mmio_hit) || (mmio_hit && off == OFF_CYCLE))) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = mem[ram_idx];
    end else if (mmio_hit) begin
      case (off)
        OFF_CYCLE: ReadData = cycle_cnt;
        OFF_TCMP:  ReadData = tcmp;
        OFF_TCTRL: ReadData = {30'd0, tmr_ar, tmr_en};
        OFF_TCNT:  ReadData = tcnt;
        OFF_TSTAT: ReadData = {31'd0, pend};
        OFF_DONE:  ReadData = done_value;
        default:   ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: the driver pushes expected values, a negedge monitor pops and compares.
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
module tb_dbus_responder;

  localparam logic [31:0] MB    = 32'hFFFF_FF00;
  localparam logic [31:0] CYCLE = MB + 32'h00;
  localparam logic [31:0] TCMP  = MB + 32'h04;
  localparam logic [31:0] TCTRL = MB + 32'h08;
  localparam logic [31:0] TCNT  = MB + 32'h0C;
  localparam logic [31:0] TSTAT = MB + 32'h10;
  localparam logic [31:0] DONE  = MB + 32'h14;

`ifdef DBUS_ERR_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  localparam int S_RD = 0, S_IRQ = 1, S_DONE = 2, S_DV = 3, S_ERR = 4;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        timer_irq;
  logic        done;
  logic [31:0] done_value;
  logic        bus_err;

  dbus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .timer_irq  (timer_irq),
    .done       (done),
    .done_value (done_value),
    .bus_err    (bus_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [31:0] m_exp, m_act;
  int          m_sel;
  string       m_tag;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_sel = sel_q.pop_front();
      m_tag = tag_q.pop_front();
      case (m_sel)
        S_RD:    m_act = ReadData;
        S_IRQ:   m_act = {31'd0, timer_irq};
        S_DONE:  m_act = {31'd0, done};
        S_DV:    m_act = done_value;
        default: m_act = {31'd0, bus_err};
      endcase
      checks++;
      if (m_act !== m_exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h", m_tag, m_act, m_exp);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [31:0] exp, input string tag);
    exp_q.push_back(exp);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = dat;
    tick();
    MemWrite  = 1'b0;
  endtask

  // Check ReadData for adr against the state left by the previous edge, then advance one edge.
  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    DataAdr = adr;
    chk(S_RD, exp, tag);
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    repeat (3) tick();
    chk(S_IRQ, 0, "rst_irq");
    chk(S_DONE, 0, "rst_done");
    chk(S_DV, 0, "rst_done_value");
    chk(S_ERR, 0, "rst_bus_err");
    rd(CYCLE, 0, "rst_cycle");

    // CYCLE counts edges after release
    reset   = 1'b1;
    DataAdr = CYCLE;
    repeat (10) tick();
    rd(CYCLE, 32'd10, "cycle_10th_edge");
    dut.cycle_cnt = 32'hFFFF_FFFF;
    tick();
    rd(CYCLE, 32'd0, "cycle_wrap");

    // RAM
    wr(32'h10, 32'hDEAD_BEEF);
    wr(32'h14, 32'h1234_5678);
    chk(S_ERR, 0, "ram_write_no_err");
    rd(32'h10, 32'hDEAD_BEEF, "ram_0x10");
    rd(32'h13, 32'hDEAD_BEEF, "ram_0x13_lowbits");
    rd(32'h14, 32'h1234_5678, "ram_0x14");
    wr(32'hFC, 32'hCAFE_F00D);
    wr(32'h00, 32'h1111_1111);
    wr(32'h100, 32'h2222_2222);
    chk(S_ERR, EXP_ERR, "unmapped_0x100_err");
    rd(32'hFC, 32'hCAFE_F00D, "ram_top_word");
    rd(32'h00, 32'h1111_1111, "ram_no_alias");
    rd(32'h100, 32'h0, "unmapped_0x100_read");

    // one-shot timer
    wr(TCMP, 32'd5);
    wr(TCNT, 32'd0);
    wr(TCTRL, 32'h1);
    repeat (5) tick();
    chk(S_IRQ, 0, "oneshot_irq_early");
    rd(TSTAT, 0, "oneshot_pend_early");
    chk(S_IRQ, 1, "oneshot_irq_6th_edge");
    rd(TSTAT, 1, "oneshot_pend_6th_edge");
    rd(TCTRL, 0, "oneshot_en_cleared");
    rd(TCNT, 32'd5, "oneshot_tcnt_hold");
    wr(TSTAT, 32'h1);
    chk(S_IRQ, 0, "w1c_irq");
    rd(TSTAT, 0, "w1c_pend");

    // autoreload and W1C/match collision
    wr(TCNT, 32'd0);
    wr(TCMP, 32'd3);
    wr(TCTRL, 32'h3);
    repeat (3) tick();
    chk(S_IRQ, 0, "ar_irq_before");
    rd(TCNT, 32'd3, "ar_tcnt_3");
    chk(S_IRQ, 1, "ar_irq_match");
    rd(TCNT, 32'd0, "ar_tcnt_reload");
    wr(TSTAT, 32'h1);
    chk(S_IRQ, 0, "ar_w1c_irq");
    rd(TSTAT, 0, "ar_w1c_pend");
    wr(TSTAT, 32'h1);
    chk(S_IRQ, 1, "collision_irq");
    rd(TSTAT, 1, "collision_pend");
    rd(TCNT, 32'd1, "ar_tcnt_after_reload");
    wr(TCNT, 32'd100);
    rd(TCNT, 32'd100, "tcnt_write_wins");
    wr(TCTRL, 32'h0);
    wr(TCNT, 32'd7);
    rd(TCNT, 32'd7, "tcnt_disabled");
    rd(TCNT, 32'd7, "tcnt_hold");
    wr(TCTRL, 32'hFFFF_FFFC);
    rd(TCTRL, 0, "tctrl_upper_bits");
    wr(TCTRL, 32'h2);
    rd(TCTRL, 32'h2, "tctrl_autoreload_bit");
    wr(TCTRL, 32'h0);
    wr(MB + 32'h18, 32'hFFFF_FFFF);
    rd(MB + 32'h18, 0, "mmio_undefined_offset");
    chk(S_IRQ, 1, "pend_still_set");

    // DONE mailbox
    wr(DONE, 32'h600D);
    chk(S_DONE, 1, "done_set");
    chk(S_DV, 32'h600D, "done_value_600d");
    rd(DONE, 32'h600D, "done_read");
    wr(DONE, 32'hBAD);
    chk(S_DONE, 1, "done_sticky");
    chk(S_DV, 32'hBAD, "done_value_bad");

    // reset asserted mid-count
    wr(TCMP, 32'd1000);
    wr(TCNT, 32'd0);
    wr(TCTRL, 32'h1);
    repeat (5) tick();
    rd(TCNT, 32'd5, "midcount_tcnt");
    reset = 1'b0;
    chk(S_IRQ, 0, "mid_rst_irq");
    chk(S_DONE, 0, "mid_rst_done");
    chk(S_DV, 0, "mid_rst_done_value");
    chk(S_ERR, 0, "mid_rst_bus_err");
    rd(CYCLE, 0, "mid_rst_cycle");
    rd(TCMP, 0, "mid_rst_tcmp");
    rd(TCTRL, 0, "mid_rst_tctrl");
    rd(TCNT, 0, "mid_rst_tcnt");
    rd(TSTAT, 0, "mid_rst_tstat");
    rd(DONE, 0, "mid_rst_done_reg");
    rd(32'h10, 32'hDEAD_BEEF, "ram_kept_in_reset");
    reset = 1'b1;
    rd(TCNT, 0, "post_rst_tcnt");

    // bus error flag
    chk(S_ERR, 0, "err_clear_before");
    wr(32'h8000_0000, 32'h55);
    chk(S_ERR, EXP_ERR, "err_unmapped_write");
    rd(32'h8000_0000, 0, "unmapped_read_zero");
    chk(S_ERR, EXP_ERR, "err_sticky");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wr(CYCLE, 32'h1234);
    chk(S_ERR, EXP_ERR, "err_cycle_write");

    tick();
    tick();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
Target end of the processor data bus (MemWrite / DataAdr / WriteData / ReadData). It replaces the plain data memory in processor top-levels and benches.
- Word RAM region at address 0.
- MMIO window holding a free-running cycle counter, a compare timer with an interrupt-pending flag, and a sticky DONE mailbox that benches poll to end simulation.
- Reads are combinational to suit the single-cycle core; all writes and state updates happen on the rising clk edge.

Parameters:
DEPTH, 64, RAM size in 32-bit words (power of 2); RAM occupies bytes 0 .. DEPTH*4-1
MMIO_BASE, 32'hFFFF_FF00, base byte address of the MMIO window (256-byte aligned)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  write strobe, sampled on rising clk
DataAdr  input  32  byte address; bits [1:0] ignored
WriteData  input  32  write data
ReadData  output  32  read data, combinational from DataAdr
timer_irq  output  1  registered copy of TSTAT.pend
done  output  1  sticky: DONE register has been written
done_value  output  32  last value written to DONE
bus_err  output  1  sticky unmapped-access flag (see Optional Feature)

Behaviour:
- Decode (word address = DataAdr[31:2]):
  - RAM hit: DataAdr < DEPTH*4.
  - MMIO hit: DataAdr[31:8] == MMIO_BASE[31:8].
  - Anything else is unmapped.
- RAM:
  - Read is combinational: ReadData = mem[DataAdr[log2(DEPTH)+1:2]].
  - Write: mem <= WriteData at the clk edge when MemWrite is high.
  - Contents are not reset.
- Unmapped or undefined MMIO offsets: reads return 0; writes are ignored.
- MMIO offsets (from MMIO_BASE):
  - 0x00 CYCLE (RO): increments every cycle; wraps 0xFFFFFFFF -> 0; writes ignored.
  - 0x04 TCMP (RW): compare value.
  - 0x08 TCTRL (RW): bit0 en, bit1 autoreload; bits [31:2] read 0.
  - 0x0C TCNT (RW): timer count.
  - 0x10 TSTAT: bit0 pend; write-1-to-clear; other bits read 0.
  - 0x14 DONE (RW): write sets done=1 and done_value=WriteData; read returns done_value.
- Timer, evaluated each edge with en=1:
  - If TCNT == TCMP: pend <= 1.
    - autoreload=1: TCNT <= 0.
    - autoreload=0: TCNT holds and en <= 0 (one-shot).
  - Otherwise TCNT <= TCNT+1, wrapping 0xFFFFFFFF -> 0.
  - With en=0, TCNT holds.
- Simultaneous events:
  - A bus write to TCNT or TCTRL beats the timer update in the same cycle.
  - A match-set of pend beats a W1C clear in the same cycle (pend stays 1).
- DONE is sticky. Later writes update done_value; done stays 1.
- timer_irq is a registered copy of pend, so it follows pend with no added delay (same edge as pend).
- Reset, asserted at any time including mid-count:
  - Registers cleared: CYCLE, TCMP, TCTRL, TCNT, pend, done, done_value, bus_err.
  - Outputs: timer_irq=0, done=0, done_value=0, bus_err=0.
  - ReadData still reflects the combinational decode during reset; MMIO reads return 0.
  - First CYCLE increment occurs on the first edge after reset deasserts.

Optional Feature:
Macro DBUS_ERR_EN.
- Defined: bus_err sets on any clk edge where MemWrite=1 and the address is unmapped, or where a write targets CYCLE. It is sticky until reset.
- Undefined: bus_err is tied to 0 and no error logic is built. Decode and read behaviour are otherwise identical.

Test Plan:
1. RAM: write 0xDEADBEEF at 0x10, then 0x12345678 at 0x14; read 0x10 -> 0xDEADBEEF, read 0x13 -> 0xDEADBEEF (low bits ignored), read 0x14 -> 0x12345678.
2. CYCLE: release reset, read MMIO_BASE+0x00 at the 10th edge after release -> 10. Force the count to 0xFFFFFFFF via hierarchical deposit; next edge -> 0.
3. One-shot timer: TCMP=5, TCNT=0, TCTRL=0x1 -> pend/timer_irq=1 six edges after the TCTRL write, TCTRL reads 0, TCNT reads 5. Write TSTAT=1 -> pend=0.
4. Autoreload and collision: TCMP=3, TCTRL=0x3 -> pend set every 4 cycles and TCNT returns to 0. A W1C issued in the same cycle as a match leaves pend=1.
5. DONE: write 0x600D at MMIO_BASE+0x14 -> done=1, done_value=0x600D; then write 0xBAD -> done stays 1, done_value=0xBAD. Assert reset mid-timer-count -> every register and output reads 0.
6. DBUS_ERR_EN: write at 0x8000_0000 -> bus_err=1 on the next edge, sticky; a read of 0x8000_0000 returns 0. Without the macro, bus_err stays 0.
